// File: rtl/e203_irq_inj_pkg.sv
// Shared types and constants for the E203 interrupt / ITCM-error injection scheduler.
package e203_irq_inj_pkg;

    typedef enum logic [1:0] {CH_IDLE, CH_WAIT, CH_ASSERT, CH_STOP} chan_state_t;
    typedef enum logic [1:0] {ERR_LOW, ERR_HIGH, ERR_STOP} err_state_t;

    localparam logic [31:0] DEF_PC_ARM     = 32'h8000015C;
    localparam logic [31:0] DEF_PC_TOHOST  = 32'h80000086;
    localparam logic [31:0] DEF_PC_EXT_ACK = 32'h800000A6;
    localparam logic [31:0] DEF_PC_SFT_ACK = 32'h800000BE;
    localparam logic [31:0] DEF_PC_TMR_ACK = 32'h800000D6;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/e203_irq_inj_chan.sv
// One interrupt channel: random wait, hold the line until the handler exit commits, repeat or stop.
module e203_irq_inj_chan
    import e203_irq_inj_pkg::*;
#(
    parameter int WAIT_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WAIT_W:0]   delay,
    input  logic              ack,
    input  logic              stop,
    input  logic              go,
    output logic              irq,
    output chan_state_t       state
);

    logic [WAIT_W:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CH_IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (go) begin
                        state <= CH_WAIT;
                        cnt   <= delay;
                    end
                end
                CH_WAIT: begin
                    if (!go) begin
                        state <= CH_IDLE;
                    end else if (cnt == (WAIT_W+1)'(1)) begin
                        state <= CH_ASSERT;
                        irq   <= 1'b1;
                    end else begin
                        cnt <= cnt - (WAIT_W+1)'(1);
                    end
                end
                CH_ASSERT: begin
                    if (!go) begin
                        state <= CH_IDLE;
                        irq   <= 1'b0;
                    end else if (ack) begin
                        irq <= 1'b0;
                        if (stop) begin
                            state <= CH_STOP;
                        end else begin
                            state <= CH_WAIT;
                            cnt   <= delay;
                        end
                    end
                end
                default: begin
                    state <= CH_STOP;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/e203_irq_inject_sched.sv
// Drives forced ext/sft/tmr interrupts and ITCM read errors into the E203 subsystem,
// paced by an LFSR and released by the handler-exit commits.
module e203_irq_inject_sched
    import e203_irq_inj_pkg::*;
#(
    parameter int                  PC_SIZE    = 32,
    parameter int                  WAIT_W     = 10,
    parameter logic [PC_SIZE-1:0]  PC_ARM     = PC_SIZE'(DEF_PC_ARM),
    parameter logic [PC_SIZE-1:0]  PC_TOHOST  = PC_SIZE'(DEF_PC_TOHOST),
    parameter logic [PC_SIZE-1:0]  PC_EXT_ACK = PC_SIZE'(DEF_PC_EXT_ACK),
    parameter logic [PC_SIZE-1:0]  PC_SFT_ACK = PC_SIZE'(DEF_PC_SFT_ACK),
    parameter logic [PC_SIZE-1:0]  PC_TMR_ACK = PC_SIZE'(DEF_PC_TMR_ACK),
    parameter int                  STOP_CNT   = 32,
    parameter int                  END_CNT    = 8,
    parameter int                  ERR_EN     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               seed_load,
    input  logic [31:0]        seed,
    input  logic               cmt_valid,
    input  logic [PC_SIZE-1:0] cmt_pc,
    input  logic               status_mie,
    input  logic               itcm_rsp_read,
    output logic               ext_irq_o,
    output logic               sft_irq_o,
    output logic               tmr_irq_o,
    output logic               itcm_err_o,
    output logic [31:0]        tohost_cnt_o,
    output logic               done_o,
    output logic               armed_o
);

    logic [31:0]  lfsr;
    logic         hit_arm;
    logic         hit_tohost;
    logic [2:0]   hit_ack;
    logic [2:0]   ack;
    logic [2:0]   irq;
    logic         go;
    logic         stop_inj;
    chan_state_t  chan_state [3];

    assign hit_arm    = cmt_valid & (cmt_pc == PC_ARM);
    assign hit_tohost = cmt_valid & (cmt_pc == PC_TOHOST);
    assign hit_ack[0] = cmt_valid & (cmt_pc == PC_EXT_ACK);
    assign hit_ack[1] = cmt_valid & (cmt_pc == PC_SFT_ACK);
    assign hit_ack[2] = cmt_valid & (cmt_pc == PC_TMR_ACK);

    assign go       = armed_o & enable;
    assign stop_inj = tohost_cnt_o > 32'(STOP_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 32'h1;
        end else if (seed_load) begin
            lfsr <= (seed == 32'h0) ? 32'h1 : seed;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_o      <= 1'b0;
            tohost_cnt_o <= '0;
            done_o       <= 1'b0;
        end else begin
            armed_o <= armed_o | hit_arm;
            if (hit_tohost && (tohost_cnt_o != 32'hFFFF_FFFF)) begin
                tohost_cnt_o <= tohost_cnt_o + 32'd1;
            end
            if ((tohost_cnt_o >= 32'(END_CNT)) && (irq == 3'b000)) begin
                done_o <= 1'b1;
            end
        end
    end

    // Channel i draws its delay from an 8*i-offset LFSR window so the three waits differ.
    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic [WAIT_W:0] delay;
        assign delay  = (WAIT_W+1)'(lfsr[8*i +: WAIT_W]) + (WAIT_W+1)'(1);
        assign ack[i] = hit_ack[i] & (chan_state[i] == CH_ASSERT);

        e203_irq_inj_chan #(
            .WAIT_W (WAIT_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .delay (delay),
            .ack   (ack[i]),
            .stop  (stop_inj),
            .go    (go),
            .irq   (irq[i]),
            .state (chan_state[i])
        );
    end

    assign ext_irq_o = irq[0];
    assign sft_irq_o = irq[1];
    assign tmr_irq_o = irq[2];

    if (ERR_EN != 0) begin : g_err
        err_state_t err_state;
        logic [8:0] err_cnt;

        // The reset count matches LFSR[3:0]+1 for the reset LFSR value of 1.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_state <= ERR_LOW;
                err_cnt   <= 9'd2;
            end else begin
                case (err_state)
                    ERR_LOW: begin
                        if (err_cnt == 9'd1) begin
                            err_state <= ERR_HIGH;
                            err_cnt   <= {1'b0, lfsr[7:0]} + 9'd1;
                        end else begin
                            err_cnt <= err_cnt - 9'd1;
                        end
                    end
                    ERR_HIGH: begin
                        if (err_cnt == 9'd1) begin
                            if (stop_inj) begin
                                err_state <= ERR_STOP;
                            end else begin
                                err_state <= ERR_LOW;
                                err_cnt   <= {5'b0, lfsr[3:0]} + 9'd1;
                            end
                        end else begin
                            err_cnt <= err_cnt - 9'd1;
                        end
                    end
                    default: err_state <= ERR_STOP;
                endcase
            end
        end

        // Only read responses under MIE get corrupted, keeping write responses and trap codes clean.
        assign itcm_err_o = (err_state == ERR_HIGH) & status_mie & itcm_rsp_read;
    end else begin : g_no_err
        assign itcm_err_o = 1'b0;
    end

endmodule

// File: tb/tb_e203_irq_inject_sched.sv
// Directed bench for e203_irq_inject_sched with a reference LFSR for the random delays.
module tb_e203_irq_inject_sched;

    localparam logic [31:0] P_ARM     = 32'h8000015C;
    localparam logic [31:0] P_TOHOST  = 32'h80000086;
    localparam logic [31:0] P_EXT_ACK = 32'h800000A6;
    localparam logic [31:0] P_SFT_ACK = 32'h800000BE;
    localparam logic [31:0] P_TMR_ACK = 32'h800000D6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed = 32'h0;
    logic        cmt_valid = 1'b0;
    logic [31:0] cmt_pc = 32'h0;
    logic        status_mie = 1'b0;
    logic        itcm_rsp_read = 1'b0;
    logic        ext_irq_o, sft_irq_o, tmr_irq_o, itcm_err_o, done_o, armed_o;
    logic [31:0] tohost_cnt_o;
    logic [2:0]  irqs;

    logic [31:0] ref_lfsr = 32'h1;
    int          checks = 0;
    int          failures = 0;

    e203_irq_inject_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .seed_load     (seed_load),
        .seed          (seed),
        .cmt_valid     (cmt_valid),
        .cmt_pc        (cmt_pc),
        .status_mie    (status_mie),
        .itcm_rsp_read (itcm_rsp_read),
        .ext_irq_o     (ext_irq_o),
        .sft_irq_o     (sft_irq_o),
        .tmr_irq_o     (tmr_irq_o),
        .itcm_err_o    (itcm_err_o),
        .tohost_cnt_o  (tohost_cnt_o),
        .done_o        (done_o),
        .armed_o       (armed_o)
    );

    assign irqs = {tmr_irq_o, sft_irq_o, ext_irq_o};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        logic [31:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 32'h80200003;
        return s;
    endfunction

    function automatic int dly(input logic [31:0] v, input int ch);
        logic [31:0] w;
        w = (v >> (8 * ch)) & 32'h3FF;
        return int'(w) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) ref_lfsr = 32'h1;
        else if (seed_load) ref_lfsr = (seed == 32'h0) ? 32'h1 : seed;
        else ref_lfsr = ref_step(ref_lfsr);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc);
        cmt_valid = 1'b1;
        cmt_pc    = pc;
        tick();
        cmt_valid = 1'b0;
        cmt_pc    = 32'h0;
    endtask

    initial begin
        int          rise [3];
        int          d [3];
        int          dn;
        int          hi_cnt;
        int          err_late;
        logic        found;
        logic        exp_done;
        logic [2:0]  prev;
        logic [31:0] ack_pc [3];

        ack_pc[0] = P_EXT_ACK;
        ack_pc[1] = P_SFT_ACK;
        ack_pc[2] = P_TMR_ACK;

        // Reset values
        repeat (3) tick();
        check("rst_irqs", irqs, 3'b000);
        check("rst_err", itcm_err_o, 0);
        check("rst_tohost", tohost_cnt_o, 0);
        check("rst_done", done_o, 0);
        check("rst_armed", armed_o, 0);

        // Seed, then arm and measure each channel's first wait
        rst_n = 1'b1;
        enable = 1'b1;
        seed = 32'h0000_0001;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        repeat (7) tick();
        check("pre_arm", armed_o, 0);
        commit(P_ARM);
        check("armed", armed_o, 1);
        for (int i = 0; i < 3; i++) begin
            d[i] = dly(ref_lfsr, i);
            rise[i] = 0;
        end
        for (int n = 1; n <= 1100; n++) begin
            tick();
            for (int i = 0; i < 3; i++)
                if (rise[i] == 0 && irqs[i]) rise[i] = n;
            if (irqs == 3'b111) break;
        end
        check("rise_ext", rise[0], d[0] + 1);
        check("rise_sft", rise[1], d[1] + 1);
        check("rise_tmr", rise[2], d[2] + 1);

        // Error channel qualifiers, all within one cycle
        status_mie = 1'b1;
        itcm_rsp_read = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 600 && !found; n++) begin
            tick();
            if (itcm_err_o) found = 1'b1;
        end
        check("err_seen", found, 1);
        status_mie = 1'b0;
        #1 check("err_mie0", itcm_err_o, 0);
        status_mie = 1'b1;
        #1 check("err_both", itcm_err_o, 1);
        itcm_rsp_read = 1'b0;
        #1 check("err_rd0", itcm_err_o, 0);
        status_mie = 1'b0;

        // ext ack: drops next cycle, reloads, others untouched
        dn = dly(ref_lfsr, 0);
        commit(P_EXT_ACK);
        check("ext_ack_fall", irqs, 3'b110);
        rise[0] = 0;
        for (int n = 1; n <= 1100; n++) begin
            tick();
            if (ext_irq_o) begin
                rise[0] = n;
                break;
            end
        end
        check("ext_reload", rise[0], dn);
        check("sft_tmr_held", irqs[2:1], 2'b11);

        // done held off by a pending tmr interrupt
        commit(P_EXT_ACK);
        commit(P_SFT_ACK);
        check("tmr_still_high", tmr_irq_o, 1);
        repeat (8) commit(P_TOHOST);
        check("tohost_8", tohost_cnt_o, 8);
        check("done_while_tmr", done_o, 0);
        commit(P_TMR_ACK);
        check("tmr_ack_fall", tmr_irq_o, 0);
        check("done_at_ack", done_o, 0);
        exp_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            prev = irqs;
            tick();
            exp_done = exp_done | (prev == 3'b000);
            check("done_follow", done_o, exp_done);
        end

        // Past STOP_CNT every acknowledged channel goes terminal
        repeat (25) commit(P_TOHOST);
        check("tohost_33", tohost_cnt_o, 33);
        for (int ch = 0; ch < 3; ch++) begin
            found = 1'b0;
            for (int n = 0; n < 1100 && !found; n++) begin
                if (irqs[ch]) found = 1'b1;
                else tick();
            end
            check("stop_wait_high", found, 1);
            commit(ack_pc[ch]);
            check("stop_ack_fall", irqs[ch], 0);
        end
        status_mie = 1'b1;
        itcm_rsp_read = 1'b1;
        hi_cnt = 0;
        err_late = 0;
        for (int n = 0; n < 5000; n++) begin
            tick();
            if (irqs != 3'b000) hi_cnt++;
            if (n >= 600 && itcm_err_o) err_late++;
        end
        check("no_irq_after_stop", hi_cnt, 0);
        check("err_stopped", err_late, 0);
        check("tohost_kept", tohost_cnt_o, 33);
        check("armed_sticky", armed_o, 1);
        status_mie = 1'b0;
        itcm_rsp_read = 1'b0;

        // Asynchronous reset in the middle of an assertion
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        commit(P_ARM);
        found = 1'b0;
        for (int n = 0; n < 1100 && !found; n++) begin
            tick();
            if (irqs != 3'b000) found = 1'b1;
        end
        check("rearm_irq", found, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_irqs", irqs, 3'b000);
        check("arst_armed", armed_o, 0);
        check("arst_tohost", tohost_cnt_o, 0);
        check("arst_done", done_o, 0);
        check("arst_err", itcm_err_o, 0);
        tick();
        #2 rst_n = 1'b1;
        hi_cnt = 0;
        for (int n = 0; n < 1200; n++) begin
            tick();
            if (irqs != 3'b000) hi_cnt++;
        end
        check("no_irq_unarmed", hi_cnt, 0);
        check("unarmed", armed_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
